// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with a prefetch queue and a req/gnt memory port.
// Redirects clear the queue and drop responses for fetches already in flight.
module fetch_prefetch_unit #(
    parameter int PC_DATA_WIDTH = 20,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter logic [PC_DATA_WIDTH-1:0] PC_INITIAL_ADDRESS = '0,
    parameter int PC_INCREMENT = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         select_new_pc_in,
    input  logic [PC_DATA_WIDTH-1:0]     new_pc_in,
    output logic                         inst_mem_req_out,
    output logic [PC_DATA_WIDTH-1:0]     inst_mem_addr_out,
    input  logic                         inst_mem_gnt_in,
    input  logic                         inst_mem_rvalid_in,
    input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_reg_out,
    output logic [PC_DATA_WIDTH-1:0]     new_pc_out,
    output logic                         inst_valid_out,
    output logic [CNT_WIDTH-1:0]         fifo_count_out
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [PC_DATA_WIDTH-1:0] PC_STEP = PC_DATA_WIDTH'(PC_INCREMENT);
    localparam logic [CNT_WIDTH:0] DEPTH = (CNT_WIDTH + 1)'(FIFO_DEPTH);

    logic [PC_DATA_WIDTH-1:0]     fetch_pc;
    logic [PC_DATA_WIDTH-1:0]     resp_pc;
    logic [PC_DATA_WIDTH-1:0]     q_pc   [FIFO_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] q_inst [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]         rd_ptr;
    logic [PTR_WIDTH-1:0]         wr_ptr;
    logic [CNT_WIDTH-1:0]         count;
    logic [CNT_WIDTH-1:0]         outstanding;
    logic [CNT_WIDTH-1:0]         drop_cnt;
    logic [CNT_WIDTH:0]           in_use;
    logic                         accept;
    logic                         resp;
    logic                         drop;
    logic                         push;
    logic                         pop;

    // Queued plus in-flight fetches never exceed the queue depth, so push never overflows
    assign in_use = {1'b0, count} + {1'b0, outstanding};
    assign inst_mem_req_out = rst_n & (in_use < DEPTH) & ~select_new_pc_in;
    assign inst_mem_addr_out = fetch_pc;
    assign accept = inst_mem_req_out & inst_mem_gnt_in;
    assign resp = inst_mem_rvalid_in & (outstanding != '0);
    assign drop = resp & (drop_cnt != '0);
    assign push = resp & ~drop & ~select_new_pc_in;
    assign pop = ~stall & ~flush & ~select_new_pc_in & (count != '0);
    assign fifo_count_out = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= PC_INITIAL_ADDRESS;
            resp_pc <= PC_INITIAL_ADDRESS;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            outstanding <= '0;
            drop_cnt <= '0;
        end else begin
            outstanding <= outstanding + CNT_WIDTH'(accept) - CNT_WIDTH'(resp);
            if (select_new_pc_in) begin
                fetch_pc <= new_pc_in;
                resp_pc <= new_pc_in;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
                drop_cnt <= outstanding - CNT_WIDTH'(resp);
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + PC_STEP;
                if (drop)
                    drop_cnt <= drop_cnt - CNT_WIDTH'(1);
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                    wr_ptr <= wr_ptr + PTR_WIDTH'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_WIDTH'(1);
                count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_pc[i] <= '0;
                q_inst[i] <= '0;
            end
        end else if (push) begin
            q_pc[wr_ptr] <= resp_pc;
            q_inst[wr_ptr] <= inst_mem_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction_reg_out <= '0;
            new_pc_out <= '0;
            inst_valid_out <= 1'b0;
        end else if (!stall) begin
            if (pop) begin
                instruction_reg_out <= q_inst[rd_ptr];
                new_pc_out <= q_pc[rd_ptr];
                inst_valid_out <= 1'b1;
            end else begin
                instruction_reg_out <= '0;
                inst_valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a small in-order memory model.
module tb_fetch_prefetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        sel = 1'b0;
    logic [19:0] new_pc = '0;
    logic        req;
    logic [19:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [19:0] pc;
    logic        valid;
    logic [2:0]  cnt;
    logic        hold = 1'b0;
    logic        stray = 1'b0;
    logic        mem_rv = 1'b0;
    logic [31:0] mem_data = '0;
    logic [19:0] pend [$];
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    assign rvalid = mem_rv | stray;
    assign rdata = stray ? 32'hDEADBEEF : mem_data;

    fetch_prefetch_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .stall               (stall),
        .flush               (flush),
        .select_new_pc_in    (sel),
        .new_pc_in           (new_pc),
        .inst_mem_req_out    (req),
        .inst_mem_addr_out   (addr),
        .inst_mem_gnt_in     (gnt),
        .inst_mem_rvalid_in  (rvalid),
        .inst_mem_data_in    (rdata),
        .instruction_reg_out (instr),
        .new_pc_out          (pc),
        .inst_valid_out      (valid),
        .fifo_count_out      (cnt)
    );

    // In-order memory: answers one cycle after grant unless held back
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            mem_rv <= 1'b0;
        end else begin
            if (req && gnt)
                pend.push_back(addr);
            if (!hold && pend.size() > 0) begin
                mem_rv <= 1'b1;
                mem_data <= {12'hC0D, pend.pop_front()};
            end else begin
                mem_rv <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gnt = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        sel = 1'b0;
        hold = 1'b0;
        stray = 1'b0;
        step();
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", cnt, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nognt_req", req, 1);
            chk("nognt_addr", addr, 0);
            chk("nognt_valid", valid, 0);
            chk("nognt_cnt", cnt, 0);
        end
        gnt = 1'b1;
        step();
        chk("seq_addr4", addr, 20'h4);
        step();
        chk("seq_addr8", addr, 20'h8);
        chk("seq_v0", valid, 0);
        step();
        chk("seq_addrC", addr, 20'hC);
        chk("seq_v1", valid, 1);
        chk("seq_pc0", pc, 20'h0);
        chk("seq_i0", instr, 32'hC0D00000);
        step();
        chk("seq_pc4", pc, 20'h4);
        chk("seq_i4", instr, 32'hC0D00004);
        step();
        chk("seq_pc8", pc, 20'h8);
        chk("seq_v8", valid, 1);

        do_reset();
        stall = 1'b1;
        gnt = 1'b1;
        repeat (10) step();
        chk("stall_cnt", cnt, 4);
        chk("stall_req", req, 0);
        chk("stall_valid", valid, 0);
        chk("stall_addr", addr, 20'h10);
        stall = 1'b0;
        step();
        chk("drain_pc0", pc, 20'h0);
        chk("drain_cnt3", cnt, 3);
        chk("drain_v", valid, 1);
        step();
        chk("drain_pc4", pc, 20'h4);
        chk("drain_cnt2", cnt, 2);
        step();
        chk("drain_pc8", pc, 20'h8);
        step();
        chk("drain_pcC", pc, 20'hC);

        do_reset();
        stall = 1'b1;
        gnt = 1'b1;
        repeat (5) step();
        chk("rd_fill", cnt, 4);
        hold = 1'b1;
        stall = 1'b0;
        step();
        chk("rd_pc0", pc, 20'h0);
        step();
        chk("rd_pc4", pc, 20'h4);
        step();
        chk("rd_pc8", pc, 20'h8);
        chk("rd_cnt1", cnt, 1);
        gnt = 1'b0;
        step();
        chk("rd_pcC", pc, 20'hC);
        chk("rd_cnt0", cnt, 0);
        sel = 1'b1;
        new_pc = 20'h100;
        hold = 1'b0;
        #1;
        chk("rd_req_off", req, 0);
        step();
        chk("rd_bubble", valid, 0);
        sel = 1'b0;
        gnt = 1'b1;
        #1;
        chk("rd_addr100", addr, 20'h100);
        chk("rd_req_on", req, 1);
        step();
        chk("rd_addr104", addr, 20'h104);
        step();
        chk("rd_dropped", cnt, 0);
        chk("rd_addr108", addr, 20'h108);
        step();
        chk("rd_push", cnt, 1);
        step();
        chk("rd_pc100", pc, 20'h100);
        chk("rd_i100", instr, 32'hC0D00100);
        chk("rd_v", valid, 1);

        do_reset();
        stall = 1'b1;
        gnt = 1'b1;
        repeat (5) step();
        gnt = 1'b0;
        stall = 1'b0;
        step();
        chk("fl_pc0", pc, 20'h0);
        step();
        chk("fl_pc4", pc, 20'h4);
        chk("fl_cnt2", cnt, 2);
        flush = 1'b1;
        step();
        chk("fl_instr", instr, 0);
        chk("fl_valid", valid, 0);
        chk("fl_pc_hold", pc, 20'h4);
        chk("fl_cnt_keep", cnt, 2);
        flush = 1'b0;
        step();
        chk("fl_pc8", pc, 20'h8);
        chk("fl_cnt1", cnt, 1);
        flush = 1'b1;
        stall = 1'b1;
        step();
        chk("fs_pc", pc, 20'h8);
        chk("fs_instr", instr, 32'hC0D00008);
        chk("fs_valid", valid, 1);
        chk("fs_cnt", cnt, 1);
        flush = 1'b0;
        stall = 1'b0;
        step();
        chk("fl_pcC", pc, 20'hC);
        chk("fl_cnt0", cnt, 0);

        do_reset();
        sel = 1'b1;
        new_pc = 20'hFFFFC;
        step();
        chk("wr_addr", addr, 20'hFFFFC);
        chk("wr_req_off", req, 0);
        sel = 1'b0;
        gnt = 1'b1;
        step();
        chk("wr_wrap", addr, 20'h00000);
        gnt = 1'b0;
        step();
        chk("wr_cnt1", cnt, 1);
        step();
        chk("wr_pc", pc, 20'hFFFFC);
        chk("wr_instr", instr, 32'hC0DFFFFC);
        chk("wr_valid", valid, 1);
        chk("wr_cnt0", cnt, 0);
        stray = 1'b1;
        step();
        chk("stray_cnt", cnt, 0);
        chk("stray_valid", valid, 0);
        stray = 1'b0;
        step();
        chk("stray_cnt2", cnt, 0);
        chk("stray_valid2", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch stage with a prefetch queue and a request/grant instruction-memory interface tolerating variable memory latency. Issues sequential fetches ahead of decode, buffers returned instructions with their PCs, and feeds the IF/ID register. A branch redirect discards queued and in-flight instructions. Sits between the instruction SRAM/cache port and the decode stage.

Parameters:
PC_DATA_WIDTH, 20, width of all PC/address signals
INSTRUCTION_WIDTH, 32, instruction word width
PC_INITIAL_ADDRESS, 20'h0, fetch PC after reset
PC_INCREMENT, 4, byte step between sequential fetches
FIFO_DEPTH, 4, prefetch queue entries (power of two, >=2); also the cap on queued plus in-flight fetches
CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of occupancy/outstanding counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold IF/ID output register
flush  in  1  load bubble into IF/ID output register
select_new_pc_in  in  1  redirect request (branch/jump taken)
new_pc_in  in  PC_DATA_WIDTH  redirect target
inst_mem_req_out  out  1  fetch request valid
inst_mem_addr_out  out  PC_DATA_WIDTH  fetch address
inst_mem_gnt_in  in  1  request accepted this cycle
inst_mem_rvalid_in  in  1  response data valid (in order)
inst_mem_data_in  in  INSTRUCTION_WIDTH  response instruction
instruction_reg_out  out  INSTRUCTION_WIDTH  IF/ID instruction
new_pc_out  out  PC_DATA_WIDTH  IF/ID PC of instruction_reg_out
inst_valid_out  out  1  IF/ID entry holds a real instruction
fifo_count_out  out  CNT_WIDTH  current queue occupancy

Behaviour:
- Reset values: fetch_pc=resp_pc=PC_INITIAL_ADDRESS; queue empty; outstanding=drop_cnt=0; instruction_reg_out=0, new_pc_out=0, inst_valid_out=0, inst_mem_req_out=0, fifo_count_out=0.
- inst_mem_addr_out=fetch_pc always. inst_mem_req_out=(fifo_count+outstanding<FIFO_DEPTH) & !select_new_pc_in; combinational from registers plus redirect; addr stable until grant.
- Accept on req&gnt: fetch_pc<=fetch_pc+PC_INCREMENT (modulo 2^PC_DATA_WIDTH, wraps silently); outstanding+1.
- Response on rvalid: if drop_cnt>0, discard, drop_cnt-1, outstanding-1. Else if outstanding>0, push {resp_pc,data}, resp_pc+=PC_INCREMENT, outstanding-1. rvalid with outstanding==0: ignored (protocol error, no state change).
- Same-cycle accept and response: outstanding net unchanged.
- Credit rule guarantees push never hits a full queue; no overflow path required. Push and pop in the same cycle allowed at any occupancy.
- Redirect (select_new_pc_in=1), highest priority: fetch_pc<=new_pc_in, resp_pc<=new_pc_in, queue cleared, no request issued; drop_cnt<=all still-in-flight fetches after this cycle's response (outstanding - rvalid, with any rvalid this cycle also discarded); pop suppressed.
- Output register (when !stall): if flush|select_new_pc_in|queue empty -> instruction_reg_out<=0, inst_valid_out<=0, new_pc_out held; else pop head -> instruction, PC, inst_valid_out<=1. When stall: outputs held, no pop; queue, fetch and redirect logic continue.
- Latency: grant at edge N, rvalid earliest N+1, pushed at end of that cycle, visible at output one edge later (no bypass).
- Reset mid-operation clears everything; stray responses afterwards are ignored by the outstanding==0 rule.

Test Plan:
- Reset release, gnt=1, 1-cycle response latency, no stall -> addresses 0,4,8,C issued back-to-back; outputs instr with new_pc_out 0,4,8 in consecutive cycles, inst_valid_out=1.
- gnt=0 for 5 cycles -> req held high, addr held 0; no output valid; fifo_count_out=0.
- stall=1 for 10 cycles, memory fast -> exactly FIFO_DEPTH=4 fetches, req drops, fifo_count_out=4; stall release drains PCs 0,4,8,C in order.
- Two fetches in flight (addr 10,14), redirect to 0x100 -> both late responses discarded, next request addr 0x100, next valid output new_pc_out=0x100.
- flush=1, stall=0 with queue non-empty -> instruction_reg_out=0, inst_valid_out=0, queue untouched; flush+stall=1 -> outputs held.
- fetch_pc=FFFFC, fetch accepted -> next addr 00000; rvalid with nothing outstanding -> ignored, count unchanged.
